// File: rtl/fir_seq_ctrl.sv
// Convolution sequencer: walks y[n] = sum h[k]*x[n-k] issuing RAM reads and MAC strobes.
// Optional FIR_SEQ_ABORT_EN: Start dropping mid-run aborts the run without DONE.
module fir_seq_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_b,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [5:0]  Ile_wsp,
  input  logic [13:0] Ile_probek,
  output logic        Pracuje,
  output logic        DONE,
  output logic        rd_en,
  output logic [5:0]  addr_wsp,
  output logic [13:0] addr_probki,
  output logic        mac_en,
  output logic        mac_clr,
  output logic        wynik_valid,
  output logic [14:0] addr_wynik
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        start_q;
  logic [5:0]  m_q, m_d;
  logic [13:0] nsmp_q, nsmp_d;
  logic [14:0] n_q, n_d, nlast_q, nlast_d;
  logic [5:0]  k_q, k_d, kmax_q, kmax_d;
  logic        first_q, first_d;
  logic [2:0]  drain_q, drain_d;
  logic        pracuje_q, pracuje_d, done_q, done_d;

  logic [RD_LAT:1]       vld_pipe, first_pipe, last_pipe;
  logic [RD_LAT:1][14:0] nw_pipe;
  logic                  wy_q;
  logic [14:0]           addr_wynik_q;

  logic              accept, issue, is_last, abort;
  logic signed [15:0] kmin_s, m1_s, kmax_s;
  logic [5:0]        kmin, kmax;

  assign accept  = (state_q == S_IDLE) && Start && !start_q;
  assign issue   = (state_q == S_ISSUE);
  assign is_last = issue && (k_q == kmax_q);

  // Window of valid k for output n, clamped to the coefficient and sample ranges
  assign kmin_s = $signed({1'b0, n_q}) - $signed({2'b0, nsmp_q}) + 16'sd1;
  assign m1_s   = $signed({10'b0, m_q}) - 16'sd1;
  assign kmax_s = ($signed({1'b0, n_q}) < m1_s) ? $signed({1'b0, n_q}) : m1_s;
  assign kmin   = kmin_s[15] ? 6'd0 : 6'(kmin_s);
  assign kmax   = 6'(kmax_s);

`ifdef FIR_SEQ_ABORT_EN
  assign abort = !Start && ((state_q == S_SETUP) || issue || (state_q == S_DRAIN));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    nsmp_d    = nsmp_q;
    n_d       = n_q;
    nlast_d   = nlast_q;
    k_d       = k_q;
    kmax_d    = kmax_q;
    first_d   = first_q;
    drain_d   = drain_q;
    pracuje_d = pracuje_q;
    done_d    = done_q;
    case (state_q)
      S_IDLE: if (accept) begin
        m_d       = Ile_wsp;
        nsmp_d    = Ile_probek;
        nlast_d   = 15'(Ile_wsp) + 15'(Ile_probek) - 15'd2;
        n_d       = '0;
        done_d    = 1'b0;
        pracuje_d = 1'b1;
        state_d   = (Ile_wsp == '0 || Ile_probek == '0) ? S_FIN : S_SETUP;
      end
      S_SETUP: begin
        k_d     = kmin;
        kmax_d  = kmax;
        first_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        first_d = 1'b0;
        if (k_q == kmax_q) begin
          if (n_q == nlast_q) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            n_d     = n_q + 15'd1;
            state_d = S_SETUP;
          end
        end else begin
          k_d = k_q + 6'd1;
        end
      end
      S_DRAIN: begin
        // Pracuje falls and DONE rises together as the drain window closes
        if (drain_q == 3'(RD_LAT)) begin
          pracuje_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_FIN;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      S_FIN: begin
        pracuje_d = 1'b0;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      pracuje_d = 1'b0;
      done_d    = done_q;
    end
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      m_q       <= '0;
      nsmp_q    <= '0;
      n_q       <= '0;
      nlast_q   <= '0;
      k_q       <= '0;
      kmax_q    <= '0;
      first_q   <= 1'b0;
      drain_q   <= '0;
      pracuje_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= Start;
      m_q       <= m_d;
      nsmp_q    <= nsmp_d;
      n_q       <= n_d;
      nlast_q   <= nlast_d;
      k_q       <= k_d;
      kmax_q    <= kmax_d;
      first_q   <= first_d;
      drain_q   <= drain_d;
      pracuje_q <= pracuje_d;
      done_q    <= done_d;
    end
  end

  // Strobe tags ride with each read; last/n get one extra stage so the MAC has settled
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      first_pipe   <= '0;
      last_pipe    <= '0;
      nw_pipe      <= '0;
      wy_q         <= 1'b0;
      addr_wynik_q <= '0;
    end else if (abort) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      wy_q       <= 1'b0;
    end else begin
      vld_pipe[1]   <= issue;
      first_pipe[1] <= issue && first_q;
      last_pipe[1]  <= is_last;
      nw_pipe[1]    <= n_q;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
        nw_pipe[i]    <= nw_pipe[i-1];
      end
      wy_q         <= last_pipe[RD_LAT];
      addr_wynik_q <= nw_pipe[RD_LAT];
    end
  end

  assign Pracuje     = pracuje_q;
  assign DONE        = done_q;
  assign rd_en       = issue;
  assign addr_wsp    = k_q;
  assign addr_probki = 14'(n_q - 15'(k_q));
  assign mac_en      = vld_pipe[RD_LAT];
  assign mac_clr     = first_pipe[RD_LAT];
  assign wynik_valid = wy_q;
  assign addr_wynik  = addr_wynik_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboarded bench for fir_seq_ctrl: a reference convolution walk fills expectation queues.
module tb_fir_seq_ctrl;
  localparam int LAT = 1;

  logic clk_b = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_b = ~clk_b;

  logic        Start = 1'b0;
  logic [5:0]  Ile_wsp = '0;
  logic [13:0] Ile_probek = '0;
  logic        Pracuje, DONE, rd_en, mac_en, mac_clr, wynik_valid;
  logic [5:0]  addr_wsp;
  logic [13:0] addr_probki;
  logic [14:0] addr_wynik;

  logic        st3 = 1'b0;
  logic [5:0]  m3 = 6'd1;
  logic [13:0] n3 = 14'd2;
  logic        pr3, dn3, rd3, me3, mc3, wv3;
  logic [5:0]  aw3;
  logic [13:0] ap3;
  logic [14:0] ay3;

  fir_seq_ctrl #(.RD_LAT(LAT)) dut (
    .clk_b(clk_b), .rst_n(rst_n), .Start(Start), .Ile_wsp(Ile_wsp), .Ile_probek(Ile_probek),
    .Pracuje(Pracuje), .DONE(DONE), .rd_en(rd_en), .addr_wsp(addr_wsp), .addr_probki(addr_probki),
    .mac_en(mac_en), .mac_clr(mac_clr), .wynik_valid(wynik_valid), .addr_wynik(addr_wynik));

  fir_seq_ctrl #(.RD_LAT(3)) u3 (
    .clk_b(clk_b), .rst_n(rst_n), .Start(st3), .Ile_wsp(m3), .Ile_probek(n3),
    .Pracuje(pr3), .DONE(dn3), .rd_en(rd3), .addr_wsp(aw3), .addr_probki(ap3),
    .mac_en(me3), .mac_clr(mc3), .wynik_valid(wv3), .addr_wynik(ay3));

  int n_chk = 0;
  int n_err = 0;
  int q_k[$], q_s[$], q_clr[$], q_wy[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every (k, n-k) pair inside both arrays, in increasing n then k
  task automatic push_model(input int m, input int n);
    if (m == 0 || n == 0) return;
    for (int o = 0; o <= m + n - 2; o++) begin
      bit first = 1'b1;
      for (int k = 0; k < m; k++) begin
        if (o - k >= 0 && o - k < n) begin
          q_k.push_back(k);
          q_s.push_back(o - k);
          q_clr.push_back(int'(first));
          first = 1'b0;
        end
      end
      q_wy.push_back(o);
    end
  endtask

  task automatic flush_q();
    q_k.delete(); q_s.delete(); q_clr.delete(); q_wy.delete();
  endtask

  always @(negedge clk_b) begin
    if (rst_n) begin
      if (rd_en) begin
        if (q_k.size() == 0) chk("rd_en_unexpected", 1, 0);
        else begin
          chk("addr_wsp", int'(addr_wsp), q_k.pop_front());
          chk("addr_probki", int'(addr_probki), q_s.pop_front());
        end
      end
      if (mac_en) begin
        if (q_clr.size() == 0) chk("mac_en_unexpected", 1, 0);
        else chk("mac_clr", int'(mac_clr), q_clr.pop_front());
      end
      if (wynik_valid) begin
        if (q_wy.size() == 0) chk("wynik_unexpected", 1, 0);
        else chk("addr_wynik", int'(addr_wynik), q_wy.pop_front());
      end
    end
  end

  task automatic do_run(input int m, input int n, input int chg);
    int pr = 0, rd = 0, wy = 0, exp_pr;
    bit started = 1'b0, ended = 1'b0;
    @(posedge clk_b); #1;
    Start = 1'b0; Ile_wsp = 6'(m); Ile_probek = 14'(n);
    @(posedge clk_b); #1;
    Start = 1'b1;
    push_model(m, n);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_b);
      rd += int'(rd_en);
      wy += int'(wynik_valid);
      if (Pracuje) begin
        if (!started) chk("done_clear_on_accept", int'(DONE), 0);
        started = 1'b1;
        pr++;
        if (chg != 0 && pr == chg) begin
          Ile_wsp    = Ile_wsp ^ 6'h15;
          Ile_probek = Ile_probek ^ 14'h5;
        end
      end else if (started) begin
        ended = 1'b1;
        break;
      end
    end
    exp_pr = (m == 0 || n == 0) ? 1 : (m + n - 1) + m * n + LAT + 1;
    chk("run_completed", int'(ended), 1);
    chk("pracuje_cycles", pr, exp_pr);
    chk("rd_en_count", rd, m * n);
    chk("wynik_count", wy, (m == 0 || n == 0) ? 0 : m + n - 1);
    chk("done_set", int'(DONE), 1);
    chk("queues_drained", q_k.size() + q_clr.size() + q_wy.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, rd, wy, pr;
    int rdc[$], mcc[$], wyc[$], wya[$];
    #1;
    chk("reset_flags", int'({Pracuje, DONE, rd_en, mac_en, mac_clr, wynik_valid}), 0);
    chk("reset_addrs", int'(addr_wsp) + int'(addr_probki) + int'(addr_wynik), 0);
    repeat (3) @(posedge clk_b);
    #1 rst_n = 1'b1;

    do_run(3, 4, 0);
    do_run(0, 5, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk_b);
      seen |= int'(Pracuje) | int'(rd_en);
    end
    chk("no_retrigger_while_high", seen, 0);
    chk("done_held", int'(DONE), 1);
    do_run(2, 3, 3);
    for (int i = 0; i < 6; i++)
      do_run(int'($urandom_range(1, 6)), int'($urandom_range(1, 9)), int'($urandom_range(0, 5)));

    // Reset in the middle of ISSUE
    @(posedge clk_b); #1;
    Start = 1'b0; Ile_wsp = 6'd4; Ile_probek = 14'd5;
    @(posedge clk_b); #1;
    Start = 1'b1;
    push_model(4, 5);
    rd = 0;
    for (int cyc = 0; cyc < 200 && rd < 3; cyc++) begin
      @(negedge clk_b);
      rd += int'(rd_en);
    end
    chk("reset_test_reached_issue", rd, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_flags", int'({Pracuje, DONE, rd_en, mac_en, mac_clr, wynik_valid}), 0);
    chk("midrun_reset_addrs", int'(addr_wsp) + int'(addr_probki) + int'(addr_wynik), 0);
    flush_q();
    Start = 1'b0;
    repeat (2) @(posedge clk_b);
    #1 rst_n = 1'b1;
    do_run(4, 5, 0);

    // RD_LAT=3 instance: M=1, N=2
    @(posedge clk_b); #1 st3 = 1'b1;
    pr = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk_b);
      pr += int'(pr3);
      if (rd3) rdc.push_back(cyc);
      if (me3) begin
        mcc.push_back(cyc);
        chk("lat3_mac_clr", int'(mc3), 1);
      end
      if (wv3) begin
        wyc.push_back(cyc);
        wya.push_back(int'(ay3));
      end
    end
    chk("lat3_rd_count", rdc.size(), 2);
    chk("lat3_mac_count", mcc.size(), 2);
    chk("lat3_wy_count", wyc.size(), 2);
    if (rdc.size() == 2 && mcc.size() == 2 && wyc.size() == 2)
      for (int i = 0; i < 2; i++) begin
        chk("lat3_mac_lag", mcc[i] - rdc[i], 3);
        chk("lat3_wy_lag", wyc[i] - rdc[i], 4);
        chk("lat3_wy_addr", wya[i], i);
      end
    chk("lat3_pracuje_cycles", pr, 8);
    chk("lat3_done", int'(dn3), 1);

    // Start dropped at the 5th read of an M=4, N=4 run
    @(posedge clk_b); #1;
    Start = 1'b0; Ile_wsp = 6'd4; Ile_probek = 14'd4;
    @(posedge clk_b); #1;
    Start = 1'b1;
    push_model(4, 4);
    rd = 0; wy = 0;
    for (int cyc = 0; cyc < 200 && rd < 5; cyc++) begin
      @(negedge clk_b);
      rd += int'(rd_en);
      wy += int'(wynik_valid);
    end
    chk("abort_test_reached_5th_rd", rd, 5);
    Start = 1'b0;
`ifdef FIR_SEQ_ABORT_EN
    @(posedge clk_b); #1;
    flush_q();
    @(negedge clk_b);
    chk("abort_pracuje_low", int'(Pracuje), 0);
    chk("abort_rd_en_low", int'(rd_en), 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk_b);
      seen |= int'(mac_en) | int'(wynik_valid) | int'(Pracuje) | int'(rd_en);
    end
    chk("abort_quiet", seen, 0);
    chk("abort_no_done", int'(DONE), 0);
`else
    for (int cyc = 0; cyc < 200 && Pracuje; cyc++) begin
      @(negedge clk_b);
      wy += int'(wynik_valid);
    end
    chk("noabort_completed", int'(Pracuje), 0);
    chk("noabort_wynik_count", wy, 7);
    chk("noabort_done", int'(DONE), 1);
    chk("noabort_queues_drained", q_k.size() + q_clr.size() + q_wy.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
